// File: rtl/power_pulse_pkg.sv
// Shared definitions for the multi-channel energy-pulse meter.
package power_pulse_pkg;

   localparam int unsigned DefNCh     = 4;
   localparam int unsigned DefCntW    = 32;
   localparam int unsigned DefFiltW   = 4;
   localparam int unsigned DefIntrLen = 9;

   // Per-channel measurement state.
   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow
   } meas_state_e;

endpackage

// File: rtl/pulse_chan_meas.sv
// One meter channel: input synchroniser, glitch filter, edge detect, high-time/period
// measurement FSM with timeout, and interrupt pulse stretcher.
module pulse_chan_meas
   import power_pulse_pkg::*;
#(
   parameter int unsigned CNT_W    = DefCntW,
   parameter int unsigned FILT_W   = DefFiltW,
   parameter int unsigned INTR_LEN = DefIntrLen
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic              i_pulse,
   input  logic [FILT_W-1:0] i_filt_len,
   input  logic [CNT_W-1:0]  i_timeout,
   output logic [CNT_W-1:0]  o_high_width,
   output logic [CNT_W-1:0]  o_period,
   output logic              o_meas_valid,
   output logic              o_timeout_flag,
   output logic              o_intrpt
);

   localparam int unsigned         IcW      = $clog2(INTR_LEN + 1);
   localparam logic [CNT_W-1:0]    CntMax   = '1;
   localparam logic [IcW-1:0]      IntrLoad = IcW'(INTR_LEN);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_filt_q;
   logic              r_filt_q_d;
   logic [FILT_W-1:0] r_filt_cnt;
   logic [FILT_W:0]   w_filt_lim;
   logic [FILT_W:0]   w_filt_nxt;
   logic              w_rise;
   logic              w_fall;

   meas_state_e       r_state;
   logic [CNT_W-1:0]  r_hi_cnt;
   logic [CNT_W-1:0]  r_per_cnt;
   logic [CNT_W-1:0]  r_hi_stage;
   logic [CNT_W-1:0]  r_high_width;
   logic [CNT_W-1:0]  r_period;
   logic              r_meas_valid;
   logic              r_timeout_flag;
   logic [IcW-1:0]    r_intr_cnt;
   logic [CNT_W-1:0]  w_hi_inc;
   logic [CNT_W-1:0]  w_per_inc;
   logic              w_timeout_hit;
   logic              w_publish;

   // A filter length of zero behaves as one.
   assign w_filt_lim = (i_filt_len == '0) ? (FILT_W + 1)'(1) : {1'b0, i_filt_len};
   assign w_filt_nxt = {1'b0, r_filt_cnt} + (FILT_W + 1)'(1);

   assign w_rise = r_filt_q & ~r_filt_q_d;
   assign w_fall = ~r_filt_q & r_filt_q_d;

   // Counters stick at all-ones instead of wrapping.
   assign w_hi_inc  = (r_hi_cnt == CntMax) ? r_hi_cnt : r_hi_cnt + CNT_W'(1);
   assign w_per_inc = (r_per_cnt == CntMax) ? r_per_cnt : r_per_cnt + CNT_W'(1);

   // A rise in the same cycle beats the timeout.
   assign w_timeout_hit = (i_timeout != '0) && (r_per_cnt >= i_timeout) && !w_rise;
   assign w_publish     = (r_state == StLow) && w_rise;

   // Synchroniser and glitch filter; keeps running while the channel is disabled.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_filt_q   <= 1'b0;
         r_filt_q_d <= 1'b0;
         r_filt_cnt <= '0;
      end else begin
         r_sync1    <= i_pulse;
         r_sync2    <= r_sync1;
         r_filt_q_d <= r_filt_q;
         if (r_sync2 == r_filt_q) begin
            r_filt_cnt <= '0;
         end else if (w_filt_nxt >= w_filt_lim) begin
            r_filt_q   <= r_sync2;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= w_filt_nxt[FILT_W-1:0];
         end
      end
   end

   // Measurement FSM with registered results and flags.
   always_ff @(posedge clkin) begin
      if (!rst_n || !i_enable) begin
         r_state        <= StIdle;
         r_hi_cnt       <= '0;
         r_per_cnt      <= '0;
         r_hi_stage     <= '0;
         r_high_width   <= '0;
         r_period       <= '0;
         r_meas_valid   <= 1'b0;
         r_timeout_flag <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_rise) begin
                  r_state   <= StHigh;
                  r_hi_cnt  <= CNT_W'(1);
                  r_per_cnt <= CNT_W'(1);
               end
            end
            StHigh: begin
               if (w_timeout_hit) begin
                  r_state        <= StIdle;
                  r_hi_cnt       <= '0;
                  r_per_cnt      <= '0;
                  r_high_width   <= '0;
                  r_period       <= '0;
                  r_meas_valid   <= 1'b0;
                  r_timeout_flag <= 1'b1;
               end else begin
                  r_per_cnt <= w_per_inc;
                  if (w_fall) begin
                     r_state    <= StLow;
                     r_hi_stage <= r_hi_cnt;
                  end else begin
                     r_hi_cnt <= w_hi_inc;
                  end
               end
            end
            StLow: begin
               if (w_rise) begin
                  r_high_width   <= r_hi_stage;
                  r_period       <= r_per_cnt;
                  r_meas_valid   <= 1'b1;
                  r_timeout_flag <= 1'b0;
                  r_state        <= StHigh;
                  r_hi_cnt       <= CNT_W'(1);
                  r_per_cnt      <= CNT_W'(1);
               end else if (w_timeout_hit) begin
                  r_state        <= StIdle;
                  r_hi_cnt       <= '0;
                  r_per_cnt      <= '0;
                  r_high_width   <= '0;
                  r_period       <= '0;
                  r_meas_valid   <= 1'b0;
                  r_timeout_flag <= 1'b1;
               end else begin
                  r_per_cnt <= w_per_inc;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Interrupt stretcher; a new publish restarts the count.
   always_ff @(posedge clkin) begin
      if (!rst_n || !i_enable) begin
         r_intr_cnt <= '0;
      end else if (w_publish) begin
         r_intr_cnt <= IntrLoad;
      end else if (r_intr_cnt != '0) begin
         r_intr_cnt <= r_intr_cnt - IcW'(1);
      end
   end

   assign o_high_width   = r_high_width;
   assign o_period       = r_period;
   assign o_meas_valid   = r_meas_valid;
   assign o_timeout_flag = r_timeout_flag;
   assign o_intrpt       = (r_intr_cnt != '0);

endmodule

// File: rtl/power_pulse_meter.sv
// Multi-channel energy-meter pulse high-time and period meter.
module power_pulse_meter
   import power_pulse_pkg::*;
#(
   parameter int unsigned N_CH     = DefNCh,
   parameter int unsigned CNT_W    = DefCntW,
   parameter int unsigned FILT_W   = DefFiltW,
   parameter int unsigned INTR_LEN = DefIntrLen
) (
   input  logic                  clkin,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       i_enable,
   input  logic [N_CH-1:0]       i_pulse_in,
   input  logic [FILT_W-1:0]     i_filt_len,
   input  logic [CNT_W-1:0]      i_timeout,
   output logic [N_CH*CNT_W-1:0] o_high_width,
   output logic [N_CH*CNT_W-1:0] o_period,
   output logic [N_CH-1:0]       o_meas_valid,
   output logic [N_CH-1:0]       o_timeout_flag,
   output logic [N_CH-1:0]       o_intrpt,
   output logic                  o_intrpt_any
);

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      pulse_chan_meas #(
         .CNT_W    (CNT_W),
         .FILT_W   (FILT_W),
         .INTR_LEN (INTR_LEN)
      ) u_chan (
         .clkin          (clkin),
         .rst_n          (rst_n),
         .i_enable       (i_enable[g]),
         .i_pulse        (i_pulse_in[g]),
         .i_filt_len     (i_filt_len),
         .i_timeout      (i_timeout),
         .o_high_width   (o_high_width[g*CNT_W +: CNT_W]),
         .o_period       (o_period[g*CNT_W +: CNT_W]),
         .o_meas_valid   (o_meas_valid[g]),
         .o_timeout_flag (o_timeout_flag[g]),
         .o_intrpt       (o_intrpt[g])
      );
   end

   assign o_intrpt_any = |o_intrpt;

endmodule
